mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Data-memory (MEM) stage of the 5-stage pipeline; the receiving end of the EX-to-MEM interface.
- Latches the EX result, control bits and destination register, then performs a load or store on an internal word-addressed data memory with configurable access latency.
- Drives stall_flag back to IF/ID/EX while an access is outstanding.
- Returns the registered branch decision (branch_out_ex_dm, pc_branch_out) that EX uses to squash its control outputs, and produces the MEM/WB register.

Parameters:
- DEPTH, 256: data memory size in 32-bit words.
- ADDR_W, 8: memory index width; log2(DEPTH).
- LAT, 2: extra wait cycles per load/store; 0 means single-cycle access.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, asynchronous, active-high.
- mem_read_in  in  1  load request from EX.
- mem_write_in  in  1  store request from EX.
- reg_write_in  in  1  writeback enable from EX.
- mem_to_reg_in  in  1  1 selects load data for writeback, 0 selects ALU result.
- alu_result_in  in  32  ALU result; word address for loads and stores.
- store_data_in  in  32  rt value to store.
- rd_in  in  5  destination register.
- branch_in  in  1  branch taken, from EX.
- pc_in  in  32  branch target, from EX.
- stall_flag  out  1  high while an access is outstanding.
- branch_out_ex_dm  out  1  registered branch_in.
- pc_branch_out  out  32  registered pc_in.
- wb_reg_write  out  1  MEM/WB writeback enable.
- wb_rd  out  5  MEM/WB destination register.
- wb_data  out  32  MEM/WB writeback data.

Behaviour:
- Reset (asynchronous): state IDLE, wait counter 0, all outputs 0. Memory contents are not reset. A pending store is dropped.
- States: IDLE, WAIT.
- Request: mem_read_in | mem_write_in sampled high in IDLE. If both are high, the store wins and no load is performed.
- Memory index: alu_result_in[ADDR_W-1:0]. Upper bits are ignored, so addresses wrap modulo DEPTH.

IDLE, non-memory op, every posedge:
- wb_reg_write<=reg_write_in, wb_rd<=rd_in, wb_data<=alu_result_in.
- Latency: 1 edge.

IDLE, memory request, LAT=0:
- Access completes on the sampling edge. A store writes mem[idx]<=store_data_in.
- wb_data<=(mem_read_in & mem_to_reg_in) ? mem[idx] : alu_result_in. The read returns the old contents.
- wb_rd and wb_reg_write are updated as for a non-memory op. stall_flag stays 0.

IDLE, memory request, LAT>0:
- Acceptance edge: latch all request fields, cnt<=LAT, stall_flag<=1, wb_reg_write<=0, state->WAIT.

WAIT:
- All inputs are ignored except reset. wb_reg_write stays 0.
- Each edge: cnt<=cnt-1.
- Edge with cnt==1: perform the latched access, update wb_* from the latched fields (same rules as LAT=0), stall_flag<=0, state->IDLE.
- stall_flag is high for exactly LAT cycles per access.
- Back-to-back requests: the next one is accepted on the first edge after returning to IDLE.

mem_to_reg:
- mem_to_reg=1 without mem_read selects alu_result.

Branch path, every edge in IDLE:
- branch_out_ex_dm<=branch_in, pc_branch_out<=pc_in. Pulse width 1 cycle.
- In WAIT, branch_out_ex_dm<=0 and pc_branch_out holds.

Optional Feature:
- Macro: DM_ADDR_CHECK_EN.
- When defined: adds output addr_fault (1 bit). A request with alu_result_in >= DEPTH performs no memory write. wb_data<=0 and wb_reg_write<=0 for that op. addr_fault goes high for one cycle on the completion edge. The LAT wait still elapses.
- When undefined: no addr_fault port; out-of-range addresses wrap as above.

Test Plan:
- LAT=2. Store 0xDEADBEEF to addr 5, then load addr 5 with rd=9, mem_to_reg=1, reg_write=1 -> stall_flag high 2 cycles for each op; at load completion wb_data=0xDEADBEEF, wb_rd=9, wb_reg_write=1.
- ALU op: reg_write=1, alu_result=0x00001234, rd=3 -> next edge wb_data=0x1234, wb_rd=3, stall_flag=0 throughout.
- branch_in=1 with pc_in=0x40 for one cycle -> branch_out_ex_dm=1 and pc_branch_out=0x40 on the next edge; branch_out_ex_dm returns to 0 on the following edge.
- Load addr 7 accepted, then a store to addr 7 presented during WAIT -> store ignored, mem[7] unchanged, load returns the prior value.
- Reset asserted mid-WAIT of a store to addr 2 (mem[2]=0x11) -> stall_flag=0 immediately, mem[2] remains 0x11, state IDLE.
- LAT=0 build: load from addr 300 with DEPTH=256 -> without the macro, wb_data=mem[44]; with DM_ADDR_CHECK_EN, addr_fault pulses, wb_reg_write=0, wb_data=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// EX-to-MEM interface: request fields driven by EX, stall and registered
// branch decision returned by MEM.
interface mem_stage_if;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic [4:0]  rd_in;
    logic        branch_in;
    logic [31:0] pc_in;
    logic        stall_flag;
    logic        branch_out_ex_dm;
    logic [31:0] pc_branch_out;

    // EX side
    modport master (
        output mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in,
        output alu_result_in, store_data_in, rd_in, branch_in, pc_in,
        input  stall_flag, branch_out_ex_dm, pc_branch_out
    );

    // MEM side
    modport slave (
        input  mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in,
        input  alu_result_in, store_data_in, rd_in, branch_in, pc_in,
        output stall_flag, branch_out_ex_dm, pc_branch_out
    );
endinterface

// File: rtl/mem_stage.sv
// Data-memory stage of the 5-stage pipeline.
// Latches the EX request, performs a load/store on a word-addressed data
// memory with LAT extra wait cycles, stalls the front end meanwhile, and
// produces the MEM/WB register plus the registered branch decision.
// Optional feature: define DM_ADDR_CHECK_EN to add an addr_fault output and
// suppress accesses whose address is >= DEPTH (otherwise addresses wrap).
module mem_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  ex,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
`ifdef DM_ADDR_CHECK_EN
    ,
    output logic        addr_fault
`endif
);

    localparam int CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Data memory; contents are never reset.
    logic [31:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        stall_q, stall_d;
    logic        branch_q, branch_d;
    logic [31:0] pc_branch_q, pc_branch_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;

    // Request fields held while the access waits out its latency
    logic        lat_read_q, lat_read_d;
    logic        lat_write_q, lat_write_d;
    logic        lat_reg_write_q, lat_reg_write_d;
    logic        lat_mem_to_reg_q, lat_mem_to_reg_d;
    logic [31:0] lat_alu_q, lat_alu_d;
    logic [31:0] lat_store_q, lat_store_d;
    logic [4:0]  lat_rd_q, lat_rd_d;

`ifdef DM_ADDR_CHECK_EN
    logic        addr_fault_q, addr_fault_d;
`endif

    // Fields of the access being performed this cycle: live inputs in IDLE,
    // latched copy in WAIT.
    logic              act_read;
    logic              act_write;
    logic              act_reg_write;
    logic              act_mem_to_reg;
    logic [31:0]       act_alu;
    logic [31:0]       act_store;
    logic [4:0]        act_rd;
    logic [ADDR_W-1:0] act_idx;
    logic              act_fault;
    logic [31:0]       act_wb_data;
    logic              act_wb_reg_write;
    logic              request;
    logic              access_now;
    logic              mem_we;

    assign request = ex.mem_read_in | ex.mem_write_in;

    // Select the access source (inputs when idle, latched fields when waiting)
    always_comb begin
        if (state_q == WAIT) begin
            act_read       = lat_read_q;
            act_write      = lat_write_q;
            act_reg_write  = lat_reg_write_q;
            act_mem_to_reg = lat_mem_to_reg_q;
            act_alu        = lat_alu_q;
            act_store      = lat_store_q;
            act_rd         = lat_rd_q;
        end else begin
            act_read       = ex.mem_read_in;
            act_write      = ex.mem_write_in;
            act_reg_write  = ex.reg_write_in;
            act_mem_to_reg = ex.mem_to_reg_in;
            act_alu        = ex.alu_result_in;
            act_store      = ex.store_data_in;
            act_rd         = ex.rd_in;
        end
    end

    assign act_idx = act_alu[ADDR_W-1:0];

`ifdef DM_ADDR_CHECK_EN
    assign act_fault = (act_alu >= 32'(DEPTH));
`else
    assign act_fault = 1'b0;
`endif

    // Writeback value of the access: a store overrides a simultaneous load,
    // and a load returns the contents from before this edge's write.
    always_comb begin
        act_wb_data = act_alu;
        if (act_fault) begin
            act_wb_data = 32'd0;
        end else if (act_read && !act_write && act_mem_to_reg) begin
            act_wb_data = mem[act_idx];
        end
    end

    assign act_wb_reg_write = act_reg_write & ~act_fault;

    // The access happens on the request edge when LAT is zero, otherwise on
    // the last WAIT edge.
    always_comb begin
        access_now = 1'b0;
        if (state_q == IDLE) begin
            access_now = request && (LAT == 0);
        end else begin
            access_now = (cnt_q == CNT_W'(1));
        end
    end

    // Reset gating drops a store that was outstanding when reset hit.
    assign mem_we = access_now & act_write & ~act_fault & ~reset;

    // Data memory write port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[act_idx] <= act_store;
        end
    end

    // Next-state logic for the stage FSM and all registered outputs
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        stall_d          = stall_q;
        branch_d         = branch_q;
        pc_branch_d      = pc_branch_q;
        wb_reg_write_d   = wb_reg_write_q;
        wb_rd_d          = wb_rd_q;
        wb_data_d        = wb_data_q;
        lat_read_d       = lat_read_q;
        lat_write_d      = lat_write_q;
        lat_reg_write_d  = lat_reg_write_q;
        lat_mem_to_reg_d = lat_mem_to_reg_q;
        lat_alu_d        = lat_alu_q;
        lat_store_d      = lat_store_q;
        lat_rd_d         = lat_rd_q;
`ifdef DM_ADDR_CHECK_EN
        addr_fault_d     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                branch_d    = ex.branch_in;
                pc_branch_d = ex.pc_in;
                if (!request) begin
                    wb_reg_write_d = ex.reg_write_in;
                    wb_rd_d        = ex.rd_in;
                    wb_data_d      = ex.alu_result_in;
                end else if (LAT == 0) begin
                    wb_reg_write_d = act_wb_reg_write;
                    wb_rd_d        = act_rd;
                    wb_data_d      = act_wb_data;
`ifdef DM_ADDR_CHECK_EN
                    addr_fault_d   = act_fault;
`endif
                end else begin
                    lat_read_d       = ex.mem_read_in;
                    lat_write_d      = ex.mem_write_in;
                    lat_reg_write_d  = ex.reg_write_in;
                    lat_mem_to_reg_d = ex.mem_to_reg_in;
                    lat_alu_d        = ex.alu_result_in;
                    lat_store_d      = ex.store_data_in;
                    lat_rd_d         = ex.rd_in;
                    cnt_d            = CNT_W'(LAT);
                    stall_d          = 1'b1;
                    wb_reg_write_d   = 1'b0;
                    state_d          = WAIT;
                end
            end
            WAIT: begin
                // Inputs are ignored; the branch pulse is suppressed and the
                // target holds.
                branch_d       = 1'b0;
                cnt_d          = cnt_q - CNT_W'(1);
                wb_reg_write_d = 1'b0;
                if (cnt_q == CNT_W'(1)) begin
                    wb_reg_write_d = act_wb_reg_write;
                    wb_rd_d        = act_rd;
                    wb_data_d      = act_wb_data;
                    stall_d        = 1'b0;
                    state_d        = IDLE;
`ifdef DM_ADDR_CHECK_EN
                    addr_fault_d   = act_fault;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            stall_q          <= 1'b0;
            branch_q         <= 1'b0;
            pc_branch_q      <= 32'd0;
            wb_reg_write_q   <= 1'b0;
            wb_rd_q          <= 5'd0;
            wb_data_q        <= 32'd0;
            lat_read_q       <= 1'b0;
            lat_write_q      <= 1'b0;
            lat_reg_write_q  <= 1'b0;
            lat_mem_to_reg_q <= 1'b0;
            lat_alu_q        <= 32'd0;
            lat_store_q      <= 32'd0;
            lat_rd_q         <= 5'd0;
`ifdef DM_ADDR_CHECK_EN
            addr_fault_q     <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            stall_q          <= stall_d;
            branch_q         <= branch_d;
            pc_branch_q      <= pc_branch_d;
            wb_reg_write_q   <= wb_reg_write_d;
            wb_rd_q          <= wb_rd_d;
            wb_data_q        <= wb_data_d;
            lat_read_q       <= lat_read_d;
            lat_write_q      <= lat_write_d;
            lat_reg_write_q  <= lat_reg_write_d;
            lat_mem_to_reg_q <= lat_mem_to_reg_d;
            lat_alu_q        <= lat_alu_d;
            lat_store_q      <= lat_store_d;
            lat_rd_q         <= lat_rd_d;
`ifdef DM_ADDR_CHECK_EN
            addr_fault_q     <= addr_fault_d;
`endif
        end
    end

    assign ex.stall_flag       = stall_q;
    assign ex.branch_out_ex_dm = branch_q;
    assign ex.pc_branch_out    = pc_branch_q;
    assign wb_reg_write        = wb_reg_write_q;
    assign wb_rd               = wb_rd_q;
    assign wb_data             = wb_data_q;
`ifdef DM_ADDR_CHECK_EN
    assign addr_fault          = addr_fault_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a LAT=2 instance driven from a vector table through a
// scoreboard, hand sequences for branch / WAIT / reset corners, and a LAT=0
// instance for the wrap-around (or address-fault) case.
module tb_mem_stage;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_stage_if ex_if ();
    mem_stage_if ex0_if ();

    logic        wb_rw, wb_rw0;
    logic [4:0]  wb_rd, wb_rd0;
    logic [31:0] wb_data, wb_data0;
`ifdef DM_ADDR_CHECK_EN
    logic        fault, fault0;
`endif

    mem_stage #(.DEPTH(256), .ADDR_W(8), .LAT(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex           (ex_if),
        .wb_reg_write (wb_rw),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
`ifdef DM_ADDR_CHECK_EN
        ,
        .addr_fault   (fault)
`endif
    );

    mem_stage #(.DEPTH(256), .ADDR_W(8), .LAT(0)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .ex           (ex0_if),
        .wb_reg_write (wb_rw0),
        .wb_rd        (wb_rd0),
        .wb_data      (wb_data0)
`ifdef DM_ADDR_CHECK_EN
        ,
        .addr_fault   (fault0)
`endif
    );

    typedef struct {
        logic        rd_req;
        logic        wr_req;
        logic        rw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [4:0]  rd;
        int          stalls;
        logic        exp_rw;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        int          stalls;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic rw, input logic m2r,
                                input logic [31:0] alu, input logic [31:0] sdata,
                                input logic [4:0] rd, input int st, input logic erw,
                                input logic [4:0] erd, input logic [31:0] ed);
        vec_t v;
        v.rd_req = r; v.wr_req = w; v.rw = rw; v.m2r = m2r;
        v.alu = alu; v.sdata = sdata; v.rd = rd; v.stalls = st;
        v.exp_rw = erw; v.exp_rd = erd; v.exp_data = ed;
        return v;
    endfunction

    task automatic nop_a();
        ex_if.mem_read_in   = 1'b0;
        ex_if.mem_write_in  = 1'b0;
        ex_if.reg_write_in  = 1'b0;
        ex_if.mem_to_reg_in = 1'b0;
        ex_if.alu_result_in = 32'd0;
        ex_if.store_data_in = 32'd0;
        ex_if.rd_in         = 5'd0;
        ex_if.branch_in     = 1'b0;
        ex_if.pc_in         = 32'd0;
    endtask

    task automatic nop_b();
        ex0_if.mem_read_in   = 1'b0;
        ex0_if.mem_write_in  = 1'b0;
        ex0_if.reg_write_in  = 1'b0;
        ex0_if.mem_to_reg_in = 1'b0;
        ex0_if.alu_result_in = 32'd0;
        ex0_if.store_data_in = 32'd0;
        ex0_if.rd_in         = 5'd0;
        ex0_if.branch_in     = 1'b0;
        ex0_if.pc_in         = 32'd0;
    endtask

    task automatic op_a(input vec_t v);
        nop_a();
        ex_if.mem_read_in   = v.rd_req;
        ex_if.mem_write_in  = v.wr_req;
        ex_if.reg_write_in  = v.rw;
        ex_if.mem_to_reg_in = v.m2r;
        ex_if.alu_result_in = v.alu;
        ex_if.store_data_in = v.sdata;
        ex_if.rd_in         = v.rd;
    endtask

    task automatic op_b(input logic r, input logic w, input logic rw, input logic m2r,
                        input logic [31:0] alu, input logic [31:0] sdata, input logic [4:0] rd);
        ex0_if.mem_read_in   = r;
        ex0_if.mem_write_in  = w;
        ex0_if.reg_write_in  = rw;
        ex0_if.mem_to_reg_in = m2r;
        ex0_if.alu_result_in = alu;
        ex0_if.store_data_in = sdata;
        ex0_if.rd_in         = rd;
    endtask

    // Drive one op on the LAT=2 instance (called at a negedge), wait for it
    // to complete, then compare against the scoreboard entry.
    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        int   n;
        e.stalls = v.stalls;
        e.rw     = v.exp_rw;
        e.rd     = v.exp_rd;
        e.data   = v.exp_data;
        sb.push_back(e);
        op_a(v);
        @(negedge clk);
        nop_a();
        n = 0;
        while (ex_if.stall_flag && n < 20) begin
            n++;
            @(negedge clk);
        end
        got = sb.pop_front();
        check({tag, ".stalls"}, 32'(n), 32'(got.stalls));
        check({tag, ".wb_reg_write"}, 32'(wb_rw), 32'(got.rw));
        check({tag, ".wb_rd"}, 32'(wb_rd), 32'(got.rd));
        check({tag, ".wb_data"}, wb_data, got.data);
`ifdef DM_ADDR_CHECK_EN
        check({tag, ".addr_fault"}, 32'(fault), 32'd0);
`endif
        $display("op %s: rw=%0b rd=%0d data=%h stalls=%0d", tag, wb_rw, wb_rd, wb_data, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              r  w  rw m2r alu           sdata         rd  st erw erd ed
        vecs[0]  = mk(0, 1, 0, 0, 32'd5,        32'hDEADBEEF, 0,  2, 0, 0,  32'd5);
        vecs[1]  = mk(1, 0, 1, 1, 32'd5,        32'd0,        9,  2, 1, 9,  32'hDEADBEEF);
        vecs[2]  = mk(0, 0, 1, 0, 32'h1234,     32'd0,        3,  0, 1, 3,  32'h1234);
        vecs[3]  = mk(0, 1, 0, 0, 32'd7,        32'hA5A50001, 0,  2, 0, 0,  32'd7);
        vecs[4]  = mk(1, 0, 1, 1, 32'd7,        32'd0,        4,  2, 1, 4,  32'hA5A50001);
        vecs[5]  = mk(1, 0, 1, 0, 32'd7,        32'd0,        6,  2, 1, 6,  32'd7);
        vecs[6]  = mk(0, 0, 1, 1, 32'h55,       32'd0,        7,  0, 1, 7,  32'h55);
        vecs[7]  = mk(1, 1, 1, 1, 32'd10,       32'hCAFE0010, 8,  2, 1, 8,  32'd10);
        vecs[8]  = mk(1, 0, 1, 1, 32'd10,       32'd0,        1,  2, 1, 1,  32'hCAFE0010);
        vecs[9]  = mk(0, 1, 0, 0, 32'd255,      32'h12345678, 0,  2, 0, 0,  32'd255);
        vecs[10] = mk(1, 0, 1, 1, 32'd255,      32'd0,        31, 2, 1, 31, 32'h12345678);
        vecs[11] = mk(0, 0, 0, 0, 32'hFFFFFFFF, 32'd0,        17, 0, 0, 17, 32'hFFFFFFFF);

        reset = 1'b1;
        nop_a();
        nop_b();
        repeat (2) @(negedge clk);
        check("reset.stall", 32'(ex_if.stall_flag), 32'd0);
        check("reset.branch", 32'(ex_if.branch_out_ex_dm), 32'd0);
        check("reset.pc", ex_if.pc_branch_out, 32'd0);
        check("reset.wb_rw", 32'(wb_rw), 32'd0);
        check("reset.wb_rd", 32'(wb_rd), 32'd0);
        check("reset.wb_data", wb_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Branch pulse in IDLE
        ex_if.branch_in = 1'b1;
        ex_if.pc_in     = 32'h40;
        @(negedge clk);
        check("br.pulse", 32'(ex_if.branch_out_ex_dm), 32'd1);
        check("br.pc", ex_if.pc_branch_out, 32'h40);
        nop_a();
        @(negedge clk);
        check("br.clear", 32'(ex_if.branch_out_ex_dm), 32'd0);
        $display("op branch: pulse at pc 0x40");

        // Branch during WAIT is suppressed and the target holds
        op_a(vecs[1]);
        ex_if.branch_in = 1'b1;
        ex_if.pc_in     = 32'h100;
        @(negedge clk);
        check("brw.accept_branch", 32'(ex_if.branch_out_ex_dm), 32'd1);
        check("brw.accept_pc", ex_if.pc_branch_out, 32'h100);
        check("brw.stall", 32'(ex_if.stall_flag), 32'd1);
        nop_a();
        ex_if.branch_in = 1'b1;
        ex_if.pc_in     = 32'h200;
        @(negedge clk);
        check("brw.wait_branch", 32'(ex_if.branch_out_ex_dm), 32'd0);
        check("brw.wait_pc", ex_if.pc_branch_out, 32'h100);
        nop_a();
        @(negedge clk);
        check("brw.done_stall", 32'(ex_if.stall_flag), 32'd0);
        check("brw.done_data", wb_data, 32'hDEADBEEF);
        $display("op branch-in-wait: data=%h", wb_data);

        // Store presented during WAIT of a load to the same address is ignored
        op_a(mk(1, 0, 1, 1, 32'd7, 32'd0, 2, 0, 0, 0, 32'd0));
        @(negedge clk);
        op_a(mk(0, 1, 0, 0, 32'd7, 32'hBAD0BAD0, 0, 0, 0, 0, 32'd0));
        @(negedge clk);
        nop_a();
        @(negedge clk);
        check("wst.stall", 32'(ex_if.stall_flag), 32'd0);
        check("wst.wb_rw", 32'(wb_rw), 32'd1);
        check("wst.wb_rd", 32'(wb_rd), 32'd2);
        check("wst.wb_data", wb_data, 32'hA5A50001);
        $display("op load-with-store-in-wait: data=%h", wb_data);
        run_vec(vecs[4], "reload7");

        // Reset in the middle of a store's WAIT drops the store
        run_vec(mk(0, 1, 0, 0, 32'd2, 32'h11, 0, 2, 0, 0, 32'd2), "store2");
        op_a(mk(0, 1, 0, 0, 32'd2, 32'h99, 0, 0, 0, 0, 32'd0));
        @(negedge clk);
        nop_a();
        check("rst.stall_before", 32'(ex_if.stall_flag), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst.stall_async", 32'(ex_if.stall_flag), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        $display("op reset-in-wait");
        run_vec(mk(1, 0, 1, 1, 32'd2, 32'd0, 12, 2, 1, 12, 32'h11), "load2");

        // LAT=0 instance: single-cycle access and out-of-range address
        op_b(0, 1, 0, 0, 32'd44, 32'h44440044, 0);
        @(negedge clk);
        check("l0.store_stall", 32'(ex0_if.stall_flag), 32'd0);
        check("l0.store_rw", 32'(wb_rw0), 32'd0);
        op_b(1, 0, 1, 1, 32'd44, 32'd0, 6);
        @(negedge clk);
        check("l0.load44_data", wb_data0, 32'h44440044);
        check("l0.load44_rd", 32'(wb_rd0), 32'd6);
        op_b(1, 0, 1, 1, 32'd300, 32'd0, 5);
        @(negedge clk);
        check("l0.load300_stall", 32'(ex0_if.stall_flag), 32'd0);
        check("l0.load300_rd", 32'(wb_rd0), 32'd5);
`ifdef DM_ADDR_CHECK_EN
        check("l0.load300_fault", 32'(fault0), 32'd1);
        check("l0.load300_rw", 32'(wb_rw0), 32'd0);
        check("l0.load300_data", wb_data0, 32'd0);
`else
        check("l0.load300_rw", 32'(wb_rw0), 32'd1);
        check("l0.load300_data", wb_data0, 32'h44440044);
`endif
        $display("op lat0 load 300: rw=%0b data=%h", wb_rw0, wb_data0);
        nop_b();
        @(negedge clk);
`ifdef DM_ADDR_CHECK_EN
        check("l0.fault_clear", 32'(fault0), 32'd0);
`endif
        check("l0.nop_rw", 32'(wb_rw0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
